mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 Parameter STARVE_MAX, default 3, number of consecutive lost fetch conflicts after which fetch wins; legal range 1..15.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 if_req  in  1  fetch-stage read request, held until granted.
REQ-007 if_addr  in  ADDR_W  fetch read address.
REQ-008 if_gnt  out  1  fetch granted this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid on mem_rdata.
REQ-010 ds_req  in  1  data-stage request, held until granted.
REQ-011 ds_we  in  1  data-stage write (1) or read (0).
REQ-012 ds_addr  in  ADDR_W  data-stage address.
REQ-013 ds_wdata  in  DATA_W  data-stage write data.
REQ-014 ds_gnt  out  1  data stage granted this cycle.
REQ-015 ds_rvalid  out  1  data-stage read data valid on mem_rdata.
REQ-016 halt  in  1  STOP-instruction indication, level or pulse.
REQ-017 mem_en, mem_we  out  1 each  single-port memory enable and write strobe.
REQ-018 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory address and write data.
REQ-019 halted  out  1  arbiter permanently idle until reset.

Function
REQ-020 The arbiter SHALL grant at most one requester per cycle; grants are combinational from the current-cycle requests and registered state.
REQ-021 In state RUN, a lone request SHALL be granted in the same cycle.
REQ-022 On a conflict (if_req and ds_req both set), ds SHALL win unless starve_cnt equals STARVE_MAX, in which case if SHALL win.
REQ-023 starve_cnt SHALL increment on each conflict lost by fetch, saturate at STARVE_MAX, and clear on any fetch grant.
REQ-024 The memory bus SHALL carry the granted requester's address and data; ds write → mem_we=1; all other cases → mem_we=0.
REQ-025 With no grant, the arbiter SHALL drive mem_en=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
REQ-026 Reads SHALL have one-cycle latency: the matching if_rvalid or ds_rvalid pulses for exactly the cycle after a read grant.
REQ-027 Writes SHALL produce no rvalid.
REQ-028 States: RUN, DRAIN, HALTED. RUN→DRAIN when halt=1 while a read is in flight; RUN→HALTED when halt=1 with nothing in flight. DRAIN→HALTED after the pending rvalid.
REQ-029 In DRAIN and HALTED the arbiter SHALL issue no grants; HALTED is left only by reset.
REQ-030 If halt and a request arrive in the same cycle, halt SHALL take priority and no grant is issued.

Reset
REQ-031 With reset=1 at a clock edge: state=RUN; starve_cnt=0; all grant, rvalid, mem_en and mem_we outputs=0; halted=0; mem_addr=0; mem_wdata=0.
REQ-032 Reset asserted mid-read SHALL suppress that read's rvalid.

Configuration
REQ-033 Macro MEM_ARB_STATS_EN compiled in SHALL add output conflict_cnt (16 bits): counts conflict cycles, saturates at 0xFFFF, and is cleared by reset.
REQ-034 With the macro absent, there SHALL be no conflict_cnt port and no counter logic.

Structure
REQ-035 Shared package mem_arb_pkg SHALL hold the state encoding (RUN, DRAIN, HALTED) and the owner encoding (NONE, IF, DS) used for the in-flight tag.
REQ-036 Starvation counting SHALL be isolated in sub-module arb_starve_ctr (inputs: lose, win; output: at_max).

Verification
REQ-037 Bench SHALL cover: if_req=1, ds_req=0, if_addr=0x10 → if_gnt=1, mem_en=1, mem_addr=0x10 same cycle; if_rvalid=1 next cycle.
REQ-038 Bench SHALL cover: both requesting continuously, STARVE_MAX=3 → grant order DS,DS,DS,IF, repeating.
REQ-039 Bench SHALL cover: ds write, addr 0x20, data 0xA5 → mem_we=1, mem_wdata=0xA5; no ds_rvalid follows.
REQ-040 Bench SHALL cover: halt during a fetch read → state DRAIN; if_rvalid=1 next cycle; then halted=1; further requests get no grant.
REQ-041 Bench SHALL cover: reset in the cycle after a read grant → no rvalid; starve_cnt=0; all outputs 0.
REQ-042 Bench SHALL cover, with MEM_ARB_STATS_EN: 5 conflict cycles → conflict_cnt=5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM state encoding and the owner tag
// of the read currently in flight.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DS   = 2'd2
   } owner_t;

   // Starvation counter width covers STARVE_MAX up to 15.
   localparam int STARVE_W = 4;
   // Width of the optional conflict statistics counter.
   localparam int STAT_W   = 16;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/grant and memory bus signals between the pipeline stages and the
// arbiter. The master side is the requesters, the slave side is the arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;

   logic              ds_req;
   logic              ds_we;
   logic [ADDR_W-1:0] ds_addr;
   logic [DATA_W-1:0] ds_wdata;
   logic              ds_gnt;
   logic              ds_rvalid;

   logic              halt;
   logic              halted;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport master (
      output if_req, if_addr, ds_req, ds_we, ds_addr, ds_wdata, halt,
      input  if_gnt, if_rvalid, ds_gnt, ds_rvalid, halted,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, ds_req, ds_we, ds_addr, ds_wdata, halt,
      output if_gnt, if_rvalid, ds_gnt, ds_rvalid, halted,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arb_starve_ctr.sv
// Fetch starvation counter: counts conflicts lost by fetch, saturating at
// STARVE_MAX, and clears whenever fetch is granted.
module arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic lose,
   input  logic win,
   output logic at_max
);

   logic [STARVE_W-1:0] cnt_q;

   assign at_max = (cnt_q == STARVE_W'(STARVE_MAX));

   // Count lost conflicts; a fetch grant always wins over a loss.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (win) begin
         cnt_q <= '0;
      end else if (lose && !at_max) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch stage (if) and the data stage
// (ds). Data stage wins conflicts unless fetch has lost STARVE_MAX in a row.
// A halt drains any in-flight read and then parks the arbiter until reset.
// Optional feature: define MEM_ARB_STATS_EN to add the conflict_cnt output.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 3
) (
   input  logic         clock,
   input  logic         reset,
   mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0] conflict_cnt
`endif
);

   state_t            state_q, state_d;
   owner_t            rd_owner_q, rd_owner_d;
   logic [ADDR_W-1:0] addr_q, mem_addr_d;
   logic [DATA_W-1:0] wdata_q, mem_wdata_d;
   logic              grant_ok;
   logic              conflict;
   logic              if_gnt, ds_gnt;
   logic              at_max;

   arb_starve_ctr #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clock  (clock),
      .reset  (reset),
      .lose   (conflict && ds_gnt),
      .win    (if_gnt),
      .at_max (at_max)
   );

   // Arbitration and memory bus drive for the current cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      grant_ok    = (state_q == RUN) && !bus.halt && !reset;
      conflict    = 1'b0;
      if_gnt      = 1'b0;
      ds_gnt      = 1'b0;
      rd_owner_d  = OWN_NONE;
      mem_addr_d  = addr_q;
      mem_wdata_d = wdata_q;

      if (grant_ok) begin
         conflict = bus.if_req && bus.ds_req;
         if_gnt   = bus.if_req && (!bus.ds_req || at_max);
         ds_gnt   = bus.ds_req && !if_gnt;
      end

      if (if_gnt) begin
         mem_addr_d = bus.if_addr;
         rd_owner_d = OWN_IF;
      end else if (ds_gnt) begin
         mem_addr_d  = bus.ds_addr;
         mem_wdata_d = bus.ds_wdata;
         rd_owner_d  = bus.ds_we ? OWN_NONE : OWN_DS;
      end
   end

   // Next-state logic: halt drains an in-flight read before parking.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (bus.halt) begin
               state_d = (rd_owner_q != OWN_NONE) ? DRAIN : HALTED;
            end
         end
         DRAIN: begin
            if (rd_owner_q == OWN_NONE) begin
               state_d = HALTED;
            end
         end
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // State, in-flight tag and held bus values.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= RUN;
         rd_owner_q <= OWN_NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         rd_owner_q <= rd_owner_d;
         addr_q     <= mem_addr_d;
         wdata_q    <= mem_wdata_d;
      end
   end

   assign bus.if_gnt    = if_gnt;
   assign bus.ds_gnt    = ds_gnt;
   // A reset arriving while the read data is due cancels the rvalid.
   assign bus.if_rvalid = (rd_owner_q == OWN_IF) && !reset;
   assign bus.ds_rvalid = (rd_owner_q == OWN_DS) && !reset;
   assign bus.mem_en    = if_gnt || ds_gnt;
   assign bus.mem_we    = ds_gnt && bus.ds_we;
   assign bus.mem_addr  = mem_addr_d;
   assign bus.mem_wdata = mem_wdata_d;
   assign bus.halted    = (state_q == HALTED);

`ifdef MEM_ARB_STATS_EN
   logic [STAT_W-1:0] conflict_q;

   // Saturating count of arbitrated conflict cycles.
   always_ff @(posedge clock) begin
      if (reset) begin
         conflict_q <= '0;
      end else if (conflict && (conflict_q != {STAT_W{1'b1}})) begin
         conflict_q <= conflict_q + 1'b1;
      end
   end

   assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. Inputs change 1 ns after the rising
// edge and outputs are compared 2 ns later, away from the edge.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

`ifdef MEM_ARB_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   mem_arbiter #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .STARVE_MAX (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef MEM_ARB_STATS_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Called 1 ns after an edge with requests already set; checks n cycles of
   // conflict outcomes, bit i of exp_if set meaning fetch wins cycle i.
   task automatic do_conflicts(input string tag, input int n, input logic [15:0] exp_if);
      for (int i = 0; i < n; i++) begin
         #2;
         check($sformatf("%s_if_gnt[%0d]", tag, i), 32'(bus.if_gnt), 32'(exp_if[i]));
         check($sformatf("%s_ds_gnt[%0d]", tag, i), 32'(bus.ds_gnt), 32'(!exp_if[i]));
         tick();
      end
   endtask

   task automatic check_idle(input string tag, input logic [7:0] exp_addr, input logic [7:0] exp_wdata);
      check({tag, "_if_gnt"},    32'(bus.if_gnt),    32'd0);
      check({tag, "_ds_gnt"},    32'(bus.ds_gnt),    32'd0);
      check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'd0);
      check({tag, "_ds_rvalid"}, 32'(bus.ds_rvalid), 32'd0);
      check({tag, "_mem_en"},    32'(bus.mem_en),    32'd0);
      check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
      check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(exp_addr));
      check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(exp_wdata));
      check({tag, "_halted"},    32'(bus.halted),    32'd0);
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b1;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.ds_req   = 1'b0;
      bus.ds_we    = 1'b0;
      bus.ds_addr  = '0;
      bus.ds_wdata = '0;
      bus.halt     = 1'b0;

      // Reset state.
      tick();
      tick();
      #2;
      check_idle("rst", 8'h00, 8'h00);
      reset = 1'b0;
      tick();

      // Lone fetch read: same-cycle grant, one-cycle rvalid pulse.
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h10;
      #2;
      check("f_if_gnt",   32'(bus.if_gnt),   32'd1);
      check("f_ds_gnt",   32'(bus.ds_gnt),   32'd0);
      check("f_mem_en",   32'(bus.mem_en),   32'd1);
      check("f_mem_we",   32'(bus.mem_we),   32'd0);
      check("f_mem_addr", 32'(bus.mem_addr), 32'h10);
      tick();
      bus.if_req = 1'b0;
      #2;
      check("f_if_rvalid",  32'(bus.if_rvalid), 32'd1);
      check("f_ds_rvalid",  32'(bus.ds_rvalid), 32'd0);
      check("f_idle_en",    32'(bus.mem_en),    32'd0);
      check("f_hold_addr",  32'(bus.mem_addr),  32'h10);
      tick();
      #2;
      check("f_rvalid_end", 32'(bus.if_rvalid), 32'd0);
      tick();

      // Continuous conflict: DS,DS,DS,IF repeating.
      bus.if_req   = 1'b1;
      bus.if_addr  = 8'h30;
      bus.ds_req   = 1'b1;
      bus.ds_we    = 1'b1;
      bus.ds_addr  = 8'h40;
      bus.ds_wdata = 8'h11;
      do_conflicts("starve", 8, 16'b1000_1000);
      bus.if_req = 1'b0;
      bus.ds_req = 1'b0;
      tick();

      // Data-stage write: strobe and data on the bus, no rvalid afterwards.
      bus.ds_req   = 1'b1;
      bus.ds_we    = 1'b1;
      bus.ds_addr  = 8'h20;
      bus.ds_wdata = 8'hA5;
      #2;
      check("w_ds_gnt",    32'(bus.ds_gnt),    32'd1);
      check("w_mem_en",    32'(bus.mem_en),    32'd1);
      check("w_mem_we",    32'(bus.mem_we),    32'd1);
      check("w_mem_addr",  32'(bus.mem_addr),  32'h20);
      check("w_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
      tick();
      bus.ds_req = 1'b0;
      #2;
      check("w_ds_rvalid", 32'(bus.ds_rvalid), 32'd0);
      check("w_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      check("w_idle_we",   32'(bus.mem_we),    32'd0);
      check("w_hold_data", 32'(bus.mem_wdata), 32'hA5);
      tick();

      // Data-stage read: ds_rvalid next cycle, write strobe low.
      bus.ds_req  = 1'b1;
      bus.ds_we   = 1'b0;
      bus.ds_addr = 8'h21;
      #2;
      check("r_ds_gnt", 32'(bus.ds_gnt), 32'd1);
      check("r_mem_we", 32'(bus.mem_we), 32'd0);
      tick();
      bus.ds_req = 1'b0;
      #2;
      check("r_ds_rvalid", 32'(bus.ds_rvalid), 32'd1);
      check("r_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      tick();

      // A lone fetch grant clears the starvation count.
      bus.if_req = 1'b1;
      bus.ds_req = 1'b1;
      bus.ds_we  = 1'b1;
      do_conflicts("pre_clr", 2, 16'b00);
      bus.ds_req = 1'b0;
      #2;
      check("clr_if_gnt", 32'(bus.if_gnt), 32'd1);
      tick();
      bus.ds_req = 1'b1;
      do_conflicts("post_clr", 4, 16'b1000);
      bus.if_req = 1'b0;
      bus.ds_req = 1'b0;
      tick();

      // Reset in the cycle after a read grant: rvalid suppressed, count cleared.
      bus.if_req   = 1'b1;
      bus.ds_req   = 1'b1;
      bus.ds_we    = 1'b0;
      bus.ds_addr  = 8'h77;
      bus.ds_wdata = 8'h3C;
      do_conflicts("pre_rst", 2, 16'b00);
      bus.if_req = 1'b0;
      bus.ds_req = 1'b0;
      reset      = 1'b1;
      #2;
      check("rst_ds_rvalid", 32'(bus.ds_rvalid), 32'd0);
      tick();
      reset = 1'b0;
      #2;
      check_idle("mid_rst", 8'h00, 8'h00);
      tick();
      bus.if_req = 1'b1;
      bus.ds_req = 1'b1;
      bus.ds_we  = 1'b1;
      do_conflicts("after_rst", 5, 16'b01000);
`ifdef MEM_ARB_STATS_EN
      #2;
      check("conflict_cnt", 32'(conflict_cnt), 32'd5);
`endif
      bus.if_req = 1'b0;
      bus.ds_req = 1'b0;
      tick();

      // Halt with nothing in flight goes straight to HALTED.
      bus.halt = 1'b1;
      #2;
      check("h_mem_en", 32'(bus.mem_en), 32'd0);
      tick();
      bus.halt = 1'b0;
      #2;
      check("h_halted", 32'(bus.halted), 32'd1);
      check("h_state",  32'(dut.state_q), 32'(HALTED));
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #2;
      check("h_rst_halted", 32'(bus.halted), 32'd0);
      tick();

      // Halt during a fetch read: DRAIN, rvalid delivered, then HALTED.
      bus.if_req  = 1'b1;
      bus.if_addr = 8'h66;
      #2;
      check("d_if_gnt", 32'(bus.if_gnt), 32'd1);
      tick();
      bus.if_req = 1'b0;
      bus.ds_req = 1'b1;
      bus.ds_we  = 1'b0;
      bus.halt   = 1'b1;
      #2;
      check("d_if_rvalid", 32'(bus.if_rvalid), 32'd1);
      check("d_halt_prio", 32'(bus.ds_gnt),    32'd0);
      tick();
      bus.halt = 1'b0;
      #2;
      check("d_state",        32'(dut.state_q),  32'(DRAIN));
      check("d_drain_halted", 32'(bus.halted),   32'd0);
      check("d_drain_gnt",    32'(bus.ds_gnt),   32'd0);
      tick();
      bus.if_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         check($sformatf("d_halted[%0d]", i), 32'(bus.halted), 32'd1);
         check($sformatf("d_no_if[%0d]", i),  32'(bus.if_gnt), 32'd0);
         check($sformatf("d_no_ds[%0d]", i),  32'(bus.ds_gnt), 32'd0);
         check($sformatf("d_no_en[%0d]", i),  32'(bus.mem_en), 32'd0);
         tick();
      end
      bus.if_req = 1'b0;
      bus.ds_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
